// File: rtl/xgs_athena_pkg.sv
// rtl/xgs_athena_pkg.sv - shared sync codes, pattern/state enums and PRBS-31 helper for the XGS athena video path
package xgs_athena_pkg;

    localparam logic [3:0]  SYNC_SOF  = 4'b0001;
    localparam logic [3:0]  SYNC_SOL  = 4'b0010;
    localparam logic [3:0]  SYNC_EOL  = 4'b0100;
    localparam logic [3:0]  SYNC_EOF  = 4'b1000;
    localparam logic [3:0]  SYNC_NONE = 4'b0000;

    localparam logic [7:0]  COUNTER_TAG = 8'hAA;
    localparam logic [30:0] PRBS_SEED   = 31'h7FFF_FFFF;

    typedef enum logic [1:0] {
        PAT_COUNTER = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_CONST   = 2'd2,
        PAT_PRBS    = 2'd3
    } tpg_pattern_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } tpg_state_t;

    typedef struct packed {
        logic [30:0] state;
        logic [63:0] data;
    } prbs_step_t;

    // Advance a Fibonacci PRBS-31 (x^31 + x^28 + 1) by 64 bits; generated bit i lands in data[i].
    function automatic prbs_step_t prbs31_step64(input logic [30:0] seed);
        prbs_step_t r;
        logic [30:0] s;
        logic        fb;
        s      = seed;
        r.data = '0;
        for (int i = 0; i < 64; i++) begin
            fb        = s[30] ^ s[27];
            s         = {s[29:0], fb};
            r.data[i] = fb;
        end
        r.state = s;
        return r;
    endfunction

endpackage

// File: rtl/xgs_tpg_pattern.sv
// rtl/xgs_tpg_pattern.sv - pixel data generator for the video source; PRBS LFSR only with XGS_TPG_PRBS_EN
module xgs_tpg_pattern
    import xgs_athena_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 seed,
    input  logic                 step,
    input  tpg_pattern_t         pattern,
    input  logic [CNT_WIDTH-1:0] line,
    input  logic [CNT_WIDTH-1:0] beat,
    input  logic [63:0]          fill,
    output logic [63:0]          data
);

    logic [63:0] counter_word;
    logic [63:0] ramp_word;
    logic [63:0] prbs_word;

    assign counter_word = {COUNTER_TAG, 24'h0, 16'(line), 16'(beat)};

    // Byte k of beat b is (8*b + k) mod 256, so the byte stream is a continuous 0x00..0xFF ramp.
    always_comb begin
        ramp_word = '0;
        for (int k = 0; k < 8; k++) begin
            ramp_word[8*k +: 8] = {beat[4:0], 3'b000} + 8'(k);
        end
    end

`ifdef XGS_TPG_PRBS_EN
    logic [30:0] lfsr;
    prbs_step_t  lfsr_next;

    assign lfsr_next = prbs31_step64(lfsr);
    assign prbs_word = lfsr_next.data;

    // LFSR restarts at every accepted frame start and advances 64 bits per handshake.
    always_ff @(posedge clk) begin
        if (reset || seed) begin
            lfsr <= PRBS_SEED;
        end else if (step) begin
            lfsr <= lfsr_next.state;
        end
    end
`else
    logic unused_prbs_ctrl;

    assign unused_prbs_ctrl = ^{clk, reset, seed, step};
    assign prbs_word        = counter_word;
`endif

    // Select the word for the current beat.
    always_comb begin
        data = counter_word;
        case (pattern)
            PAT_COUNTER: data = counter_word;
            PAT_RAMP:    data = ramp_word;
            PAT_CONST:   data = fill;
            PAT_PRBS:    data = prbs_word;
            default:     data = counter_word;
        endcase
    end

endmodule

// File: rtl/xgs_axis_video_src.sv
// rtl/xgs_axis_video_src.sv - programmable AXI-Stream video line source (optional PRBS via XGS_TPG_PRBS_EN)
module xgs_axis_video_src
    import xgs_athena_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_USER_WIDTH = 4,
    parameter int LINE_CNT_WIDTH  = 16,
    parameter int GAP_CNT_WIDTH   = 8
) (
    input  logic                       axi_clk,
    input  logic                       axi_reset,
    input  logic                       start,
    input  logic [LINE_CNT_WIDTH-1:0]  cfg_line_beats,
    input  logic [LINE_CNT_WIDTH-1:0]  cfg_lines,
    input  logic [GAP_CNT_WIDTH-1:0]   cfg_gap,
    input  logic [1:0]                 cfg_pattern,
    input  logic [63:0]                cfg_fill,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_USER_WIDTH-1:0] m_axis_tuser,
    output logic                       m_axis_tlast,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       cfg_error
);

    localparam logic [LINE_CNT_WIDTH-1:0] CNT_ONE = LINE_CNT_WIDTH'(1);
    localparam logic [GAP_CNT_WIDTH-1:0]  GAP_ONE = GAP_CNT_WIDTH'(1);

    tpg_state_t                state;
    tpg_state_t                state_nxt;

    logic [LINE_CNT_WIDTH-1:0] beats_q;
    logic [LINE_CNT_WIDTH-1:0] lines_q;
    logic [GAP_CNT_WIDTH-1:0]  gap_q;
    tpg_pattern_t              pattern_q;
    logic [63:0]               fill_q;

    logic [LINE_CNT_WIDTH-1:0] beat_cnt;
    logic [LINE_CNT_WIDTH-1:0] line_cnt;
    logic [GAP_CNT_WIDTH-1:0]  gap_cnt;
    logic                      cfg_error_q;

    logic                      cfg_ok;
    logic                      start_ok;
    logic                      handshake;
    logic                      last_beat;
    logic                      last_line;
    logic                      valid;
    logic                      tlast;
    logic [3:0]                sync;
    logic [63:0]               pat_data;

    assign cfg_ok    = (cfg_line_beats != '0) && (cfg_lines != '0);
    assign start_ok  = (state == IDLE) && start && cfg_ok;
    assign last_beat = (beat_cnt == beats_q - CNT_ONE);
    assign last_line = (line_cnt == lines_q - CNT_ONE);
    assign handshake = valid && m_axis_tready;

    // State register.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and stream outputs; sync bits OR together when a line is a single beat.
    always_comb begin
        state_nxt = state;
        valid     = 1'b0;
        tlast     = 1'b0;
        sync      = SYNC_NONE;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                valid = 1'b1;
                tlast = last_beat;
                if (beat_cnt == '0) begin
                    sync = sync | ((line_cnt == '0) ? SYNC_SOF : SYNC_SOL);
                end
                if (last_beat) begin
                    sync = sync | (last_line ? SYNC_EOF : SYNC_EOL);
                end
                if (m_axis_tready && last_beat) begin
                    if (last_line) begin
                        state_nxt = DONE;
                    end else if (gap_q == '0) begin
                        state_nxt = ACTIVE;
                    end else begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == gap_q - GAP_ONE) begin
                    state_nxt = ACTIVE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Configuration latch, beat/line/gap counters and the rejected-start pulse.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            beats_q     <= '0;
            lines_q     <= '0;
            gap_q       <= '0;
            pattern_q   <= PAT_COUNTER;
            fill_q      <= '0;
            beat_cnt    <= '0;
            line_cnt    <= '0;
            gap_cnt     <= '0;
            cfg_error_q <= 1'b0;
        end else begin
            cfg_error_q <= (state == IDLE) && start && !cfg_ok;
            case (state)
                IDLE: begin
                    if (start) begin
                        beats_q   <= cfg_line_beats;
                        lines_q   <= cfg_lines;
                        gap_q     <= cfg_gap;
                        pattern_q <= tpg_pattern_t'(cfg_pattern);
                        fill_q    <= cfg_fill;
                        beat_cnt  <= '0;
                        line_cnt  <= '0;
                        gap_cnt   <= '0;
                    end
                end
                ACTIVE: begin
                    gap_cnt <= '0;
                    if (handshake) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            if (!last_line) begin
                                line_cnt <= line_cnt + CNT_ONE;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_ONE;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GAP_ONE;
                end
                DONE: begin
                    line_cnt <= '0;
                    beat_cnt <= '0;
                end
                default: begin
                    gap_cnt <= '0;
                end
            endcase
        end
    end

    xgs_tpg_pattern #(
        .CNT_WIDTH (LINE_CNT_WIDTH)
    ) u_pattern (
        .clk     (axi_clk),
        .reset   (axi_reset),
        .seed    (start_ok),
        .step    (handshake),
        .pattern (pattern_q),
        .line    (line_cnt),
        .beat    (beat_cnt),
        .fill    (fill_q),
        .data    (pat_data)
    );

    assign m_axis_tvalid = valid;
    assign m_axis_tlast  = tlast;
    assign m_axis_tuser  = AXIS_USER_WIDTH'(sync);
    assign m_axis_tdata  = valid ? AXIS_DATA_WIDTH'(pat_data) : '0;
    assign busy          = (state != IDLE);
    assign frame_done    = (state == DONE);
    assign cfg_error     = cfg_error_q;

endmodule

// File: doc/xgs_axis_video_src.md
Name: xgs_axis_video_src

Overview:
- Programmable AXI-Stream video line source: the transmitting end of the 64-bit video stream that the XGS_athena DMA path receives.
- Emits frames of N lines × M beats with tuser sync codes and tlast per line.
- Used as a synthesizable stimulus source in validation builds and as a test-pattern generator in front of the DMA.
- Configuration is latched on a start pulse; AXI-Stream backpressure is fully honoured.

Parameters:
- AXIS_DATA_WIDTH, 64, tdata width; only 64 is supported.
- AXIS_USER_WIDTH, 4, tuser width carrying the sync code.
- LINE_CNT_WIDTH, 16, width of the line count and line-size configuration inputs.
- GAP_CNT_WIDTH, 8, width of the inter-line gap configuration input.

Ports:
- axi_clk  in  1  sole clock.
- axi_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that launches one frame.
- cfg_line_beats  in  LINE_CNT_WIDTH  beats per line (line_size/8).
- cfg_lines  in  LINE_CNT_WIDTH  lines per frame.
- cfg_gap  in  GAP_CNT_WIDTH  idle cycles between lines.
- cfg_pattern  in  2  0 = counter, 1 = byte ramp, 2 = constant, 3 = PRBS (optional feature).
- cfg_fill  in  64  constant value used by pattern 2.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tdata  out  64  pixel data.
- m_axis_tuser  out  AXIS_USER_WIDTH  sync code.
- m_axis_tlast  out  1  last beat of each line.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse at frame end.
- cfg_error  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset values: tvalid, tlast, busy, frame_done and cfg_error are 0; tdata and tuser are 0; FSM is in IDLE; all counters are 0.
- Reset takes effect at the next axi_clk edge, including mid-frame: tvalid drops with no completion beat.

FSM states: IDLE, ACTIVE, GAP, DONE.
- IDLE: on start, latch all cfg_* inputs.
  - If cfg_line_beats == 0 or cfg_lines == 0: pulse cfg_error for 1 cycle and stay in IDLE.
  - Otherwise go to ACTIVE. busy = 1 and tvalid = 1 on the next cycle, so start-to-first-valid latency is 1 cycle.
- ACTIVE: beat counter b advances only on a handshake (tvalid & tready).
  - On the handshake of beat b = line_beats-1:
    - if line l == lines-1, go to DONE;
    - else if gap == 0, go to ACTIVE with l+1, back-to-back;
    - else go to GAP.
- GAP: tvalid = 0 for exactly gap cycles, then go to ACTIVE.
- DONE: frame_done = 1 and tvalid = 0 for one cycle, then IDLE. busy falls in the same cycle the FSM reaches IDLE.
- start while busy is ignored: no error pulse, no effect on the running frame.
- AXI-Stream rules:
  - tdata, tuser and tlast are stable while tvalid & !tready.
  - tvalid never deasserts without a handshake, except on reset.
- tlast = 1 on beat line_beats-1 of every line.
- tuser sync code, one-hot:
  - bit0 (SOF): beat 0 of line 0.
  - bit1 (SOL): beat 0 of lines > 0.
  - bit2 (EOL): last beat of lines < lines-1.
  - bit3 (EOF): last beat of the last line.
  - All other beats carry 0000.
  - When line_beats == 1, the SOF/SOL bit and the EOL/EOF bit are ORed on the same beat.
- Patterns:
  - Pattern 0: tdata = {8'hAA, 24'h0, l[15:0], b[15:0]}.
  - Pattern 1: byte k = (b*8 + k) mod 256.
  - Pattern 2: tdata = cfg_fill.
- Counters are LINE_CNT_WIDTH wide. The max config (65535 × 65535) completes without wrap.

Optional Feature:
- Macro: XGS_TPG_PRBS_EN.
  - Defined: pattern 3 produces PRBS-31 (x^31 + x^28 + 1). The LFSR is seeded to 31'h7FFFFFFF at frame start and advances 64 bits per handshake (parallel step).
  - Undefined: pattern 3 behaves exactly as pattern 0 and no LFSR logic is synthesized.

Decomposition:
- xgs_athena_pkg gains:
  - sync code constants SYNC_SOF = 4'b0001, SYNC_SOL = 4'b0010, SYNC_EOL = 4'b0100, SYNC_EOF = 4'b1000;
  - enum tpg_pattern_t;
  - enum tpg_state_t {IDLE, ACTIVE, GAP, DONE}.
- One sub-module, xgs_tpg_pattern: combinational/registered data generation from (pattern, l, b, fill, LFSR state), with a step enable driven by the handshake.

Test Plan:
- Single-line frame (lines = 1, beats = 512, gap = 0, pattern 0, tready = 1):
  - beat 0 = 64'hAA00000000000000 with tuser 0001;
  - beat 511 = 64'hAA000000000001FF with tuser 1000 and tlast;
  - frame_done pulses 1 cycle after the last handshake.
- Multi-line frame (lines = 3, beats = 4, gap = 2):
  - tuser per line: 0001/0000/0000/0100, then 0010/…/0100, then 0010/…/1000;
  - exactly 2 idle cycles between lines; 12 total handshakes.
- Backpressure: random tready at 30% with pattern 1.
  - Data stays stable while stalled; byte stream is 0x00..0xFF repeating with no gaps or duplicates.
- Error and ignore cases:
  - start with cfg_lines = 0 → cfg_error pulse, busy stays 0, no tvalid;
  - start during a frame → ignored, the frame completes unchanged.
- Reset mid-frame: assert axi_reset at beat 5 of line 1.
  - All outputs are 0 the next cycle.
  - A subsequent start produces a clean frame beginning with SOF.
- With XGS_TPG_PRBS_EN defined, pattern 3 output is checked against a PRBS-31 reference model over 1000 beats. Undefined, pattern 3 output equals pattern 0.
